// File: rtl/super_alu.sv
// super_alu: single-cycle-latency 32-bit ALU for the SIMD image datapath.
// Executes ADD, SUB, AND, OR, MUL, PIXAVG and THRESH and registers the
// result together with the {N, Z, C, V} condition flags.
module super_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Control,
  output logic [3:0]  Flags,
  output logic [31:0] Result
);

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_MUL    = 3'b100,
    OP_PIXAVG = 3'b101,
    OP_THRESH = 3'b110,
    OP_RSVD   = 3'b111
  } op_t;

  // Reciprocal of 3 in Q0.11: floor(s * 683 / 2048) == floor(s / 3) for
  // every pixel sum 0..765 (the approximation error stays below 1/3).
  localparam logic [10:0] RECIP3 = 11'd683;

  op_t         op;
  logic        sub_mode;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        add_carry;
  logic        add_ovf;
  logic [63:0] product;
  logic        mul_hi_nz;
  logic [9:0]  pix_sum;
  logic [20:0] pix_avg;
  logic        a_ge_b;
  logic [31:0] result_next;
  logic [3:0]  flags_next;
  logic [31:0] result_reg;
  logic [3:0]  flags_reg;

  assign op = op_t'(Control);

  // Shared adder: SUB and THRESH both use A + ~B + 1; the carry out of the
  // subtraction is 1 exactly when A >= B (unsigned, no borrow).
  always_comb begin
    sub_mode  = (op == OP_SUB) || (op == OP_THRESH);
    b_eff     = sub_mode ? ~B : B;
    sum       = {1'b0, A} + {1'b0, b_eff} + {32'd0, sub_mode};
    add_carry = sum[32];
    // Overflow when both adder inputs share a sign the result does not.
    add_ovf   = (A[31] == b_eff[31]) && (sum[31] != A[31]);
    a_ge_b    = sum[32];
  end

  // Full 64-bit unsigned product; the upper half only feeds the carry flag.
  always_comb begin
    product   = {32'd0, A} * {32'd0, B};
    mul_hi_nz = |product[63:32];
  end

  // Pixel luminance average: sum three 8-bit channels, then divide by 3
  // with a constant multiply and shift (no iterative divider).
  always_comb begin
    pix_sum = {2'b00, A[23:16]} + {2'b00, A[15:8]} + {2'b00, A[7:0]};
    pix_avg = ({11'd0, pix_sum} * {10'd0, RECIP3}) >> 11;
  end

  // Result select and flag generation from the selected result.
  always_comb begin
    result_next = 32'd0;
    flags_next  = 4'b0000;
    case (op)
      OP_ADD: begin
        result_next   = sum[31:0];
        flags_next[1] = add_carry;
        flags_next[0] = add_ovf;
      end
      OP_SUB: begin
        result_next   = sum[31:0];
        flags_next[1] = add_carry;
        flags_next[0] = add_ovf;
      end
      OP_AND:    result_next = A & B;
      OP_OR:     result_next = A | B;
      OP_MUL: begin
        result_next   = product[31:0];
        flags_next[1] = mul_hi_nz;
      end
      OP_PIXAVG: result_next = {11'd0, pix_avg};
      OP_THRESH: result_next = a_ge_b ? 32'h0000_00FF : 32'h0000_0000;
      OP_RSVD:   result_next = 32'd0;
      default:   result_next = 32'd0;
    endcase
    flags_next[3] = result_next[31];
    flags_next[2] = (result_next == 32'd0);
  end

  // Output register: cleared asynchronously, loaded every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= 32'd0;
      flags_reg  <= 4'b0000;
    end else begin
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign Result = result_reg;
  assign Flags  = flags_reg;

endmodule

// File: tb/tb_super_alu.sv
// tb_super_alu: scoreboard bench for super_alu. Stimulus is driven on the
// falling edge and the expected response queued; a monitor pops one entry
// after each rising edge and compares it with Result/Flags.
module tb_super_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  Control;
  logic [3:0]  Flags;
  logic [31:0] Result;

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  super_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .Control(Control),
    .Flags  (Flags),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the arithmetic definitions.
  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [63:0] wide;
    longint      sr;
    int          s;
    logic        cf;
    logic        vf;
    e.c = c; e.a = a; e.b = b;
    e.r = 32'd0; cf = 1'b0; vf = 1'b0;
    case (c)
      3'd0: begin
        wide = {32'd0, a} + {32'd0, b};
        e.r  = wide[31:0];
        cf   = (wide > 64'hFFFF_FFFF);
        sr   = longint'($signed(a)) + longint'($signed(b));
        vf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        e.r = a - b;
        cf  = (a >= b);
        sr  = longint'($signed(a)) - longint'($signed(b));
        vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: begin
        wide = {32'd0, a} * {32'd0, b};
        e.r  = wide[31:0];
        cf   = (wide > 64'hFFFF_FFFF);
      end
      3'd5: begin
        s   = (int'(a[23:16]) + int'(a[15:8]) + int'(a[7:0])) / 3;
        e.r = 32'(s);
      end
      3'd6: e.r = (a >= b) ? 32'd255 : 32'd0;
      default: e.r = 32'd0;
    endcase
    e.f = {e.r[31], (e.r == 32'd0), cf, vf};
    return e;
  endfunction

  task automatic issue(input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    Control = c;
    A       = a;
    B       = b;
    exp_q.push_back(model(c, a, b));
  endtask

  task automatic op(input logic [2:0] c, input logic [31:0] a,
                    input logic [31:0] b);
    @(negedge clk);
    issue(c, a, b);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (Result !== 32'd0 || Flags !== 4'b0000) begin
      errors++;
      $display("FAIL %s: Result=%h Flags=%b, required Result=00000000 Flags=0000",
               name, Result, Flags);
    end
  endtask

  // Monitor: each rising edge retires the oldest outstanding operation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Result !== e.r || Flags !== e.f) begin
          errors++;
          $display("FAIL op%0d a=%h b=%h: Result=%h Flags=%b, required Result=%h Flags=%b",
                   e.c, e.a, e.b, Result, Flags, e.r, e.f);
        end else begin
          $display("op%0d a=%h b=%h -> Result=%h Flags=%b", e.c, e.a, e.b, Result, Flags);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          w;
    rst_n   = 1'b0;
    A       = 32'hDEAD_BEEF;
    B       = 32'h1234_5678;
    Control = 3'd0;
    #3;
    check_reset("reset_initial");
    @(posedge clk); #1;
    A = 32'hFFFF_FFFF; Control = 3'd4;
    @(posedge clk); #1;
    check_reset("reset_held");

    // Release on a falling edge; the next rising edge is the first sampled.
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 32'd1, 32'd14);

    // ADD / SUB
    op(3'd0, 32'd1, 32'd15);
    op(3'd0, 32'd0, 32'd0);
    op(3'd0, 32'hFFFF_FFFF, 32'd1);
    op(3'd0, 32'h7FFF_FFFF, 32'd1);
    op(3'd1, 32'd2, 32'd1);
    op(3'd1, 32'd0, 32'd13);
    op(3'd1, 32'd4, 32'd4);
    op(3'd1, 32'h8000_0000, 32'd1);
    // Logic
    op(3'd2, 32'd4, 32'd2);
    op(3'd2, 32'd6, 32'd2);
    op(3'd3, 32'd1, 32'd14);
    op(3'd3, 32'd9, 32'd5);
    op(3'd3, 32'd3, 32'd3);
    // MUL
    op(3'd4, 32'd10, 32'd10);
    op(3'd4, 32'd1, 32'd1);
    op(3'd4, 32'd7, 32'd5);
    op(3'd4, 32'd20, 32'd7);
    op(3'd4, 32'h0001_0000, 32'h0001_0000);
    // PIXAVG
    op(3'd5, 32'h000A_0A0A, 32'd0);
    op(3'd5, 32'h000A_0500, 32'd0);
    op(3'd5, 32'h0050_5003, 32'd0);
    op(3'd5, 32'h000A_0908, 32'd0);
    op(3'd5, 32'hFFFF_FFFF, 32'h1234_5678);
    op(3'd5, 32'h00FF_FEFE, 32'd0);
    // THRESH and reserved
    op(3'd6, 32'd10, 32'd10);
    op(3'd6, 32'd1, 32'd10);
    op(3'd6, 32'd7, 32'd5);
    op(3'd6, 32'd4, 32'd5);
    op(3'd6, 32'h8000_0000, 32'h7FFF_FFFF);
    op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(3'd0, 32'd5, 32'd6);

    // Drain, then assert reset between edges: outputs must clear at once.
    @(posedge clk); #2;
    @(negedge clk);
    A = $urandom; B = $urandom; Control = 3'($urandom_range(0, 6));
    rst_n = 1'b0;
    #1;
    check_reset("reset_async_assert");
    @(posedge clk); #1;
    check_reset("reset_async_hold");
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd3, 32'h0000_00F0, 32'h0000_000F);

    // Randomised back-to-back operations with corner-biased operands.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: ra = $urandom_range(0, 20);
        1: ra = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'h7FFF_FFFF};
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 20);
        1: rb = ra;
        default: rb = $urandom;
      endcase
      op(3'($urandom_range(0, 7)), ra, rb);
    end

    // Bounded drain of the scoreboard.
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: outstanding=%0d, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/super_alu.md
# super_alu

Single-cycle-latency 32-bit arithmetic/logic unit for the SIMD image-processing datapath. It executes one of seven operations per clock, selected by a 3-bit control code: add, subtract, AND, OR, multiply, pixel average and threshold. It also registers the result together with four condition flags. It sits in the execute stage; the operand-select logic in front of it and the writeback stage behind it are outside this block.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- A  in  32  operand A; for pixel average, packed pixel 0x00RRGGBB.
- B  in  32  operand B; ignored by pixel average.
- Control  in  3  operation select (encoding below).
- Flags  out  4  registered flags {N, Z, C, V} = Flags[3:0].
- Result  out  32  registered result.

## Operation
- Control encoding and Result:
  - 000 ADD: A + B, modulo 2^32.
  - 001 SUB: A − B, computed as A + ~B + 1, modulo 2^32.
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 MUL: unsigned A × B; Result = low 32 bits of the 64-bit product.
  - 101 PIXAVG: R = A[23:16], G = A[15:8], Bl = A[7:0]; Result = zero-extended floor((R+G+Bl)/3).
    - Sum is 10 bits wide, maximum 765.
    - Quotient is at most 255.
    - A[31:24] is ignored.
  - 110 THRESH: Result = 32'h000000FF if A ≥ B (unsigned compare), otherwise 32'h00000000.
  - 111 reserved: Result = 0; flags computed from that 0 (Z=1, N=C=V=0).
- Flags, computed from the new Result:
  - N = Result[31].
  - Z = (Result == 0).
  - C:
    - ADD: carry out of bit 31.
    - SUB: carry out of A + ~B + 1, so 1 means no borrow.
    - MUL: 1 if the upper 32 product bits are nonzero.
    - All other operations: 0.
  - V:
    - ADD: two's-complement overflow, (A[31]==B[31]) && (Result[31]!=A[31]).
    - SUB: (A[31]!=B[31]) && (Result[31]!=A[31]).
    - All other operations: 0.
- The next-state logic is fully combinational. Divide-by-3 is implemented combinationally (constant-multiply/shift or equivalent), with no iterative divider.

## Timing
- Reset: while rst_n = 0, Result = 0 and Flags = 4'b0000, regardless of clk. Deassertion takes effect at the next rising edge.
- Latency: exactly 1 cycle. A, B and Control are sampled at rising edge k; Result and Flags reflect them after edge k and hold until edge k+1.
- Throughput: one operation per cycle. There is no handshake and no stall; a new operation is accepted every edge.
- Changes to A, B or Control between edges have no effect on the outputs.
- Reset asserted mid-stream clears the outputs immediately. The first valid output after release comes from the inputs sampled at the first rising edge with rst_n = 1.
- Outputs are glitch-free (registered).

## Test plan
- Reset: hold rst_n = 0 with arbitrary inputs -> Result = 0, Flags = 0. Release, apply ADD 1 + 14 -> after the next edge Result = 15, Flags = 0000.
- ADD/SUB:
  - 1 + 15 -> 16, Flags = 0000.
  - 0 + 0 -> 0, Z = 1.
  - 0xFFFFFFFF + 1 -> 0, Z = 1, C = 1.
  - 0x7FFFFFFF + 1 -> 0x80000000, N = 1, V = 1.
  - 2 − 1 -> 1, C = 1.
  - 0 − 13 -> 0xFFFFFFF3, N = 1, C = 0.
  - 4 − 4 -> 0, Z = 1, C = 1.
- Logic:
  - AND 4 & 2 -> 0, Z = 1.
  - AND 6 & 2 -> 2.
  - OR 1 | 14 -> 15.
  - OR 9 | 5 -> 13.
  - OR 3 | 3 -> 3.
- MUL:
  - 10×10 -> 100.
  - 1×1 -> 1.
  - 7×5 -> 35.
  - 20×7 -> 140.
  - 0x00010000 × 0x00010000 -> 0, Z = 1, C = 1.
- PIXAVG:
  - 0x000A0A0A -> 10.
  - 0x000A0500 -> 5.
  - 0x00505003 -> 54.
  - 0x000A0908 -> 9.
  - 0xFFFFFFFF -> 255 (A[31:24] ignored).
- THRESH and reserved:
  - (10,10) -> 0xFF.
  - (1,10) -> 0, Z = 1.
  - (7,5) -> 0xFF.
  - (4,5) -> 0.
  - Control = 111 -> Result 0, Flags = 0100.
  - Back-to-back ops on consecutive edges: each result appears exactly one cycle after its inputs.
